// File: rtl/logs_pkg.sv
// logs_pkg: constants and types shared by the PWM audio capture path.
//   DEFAULT_WINDOW / DEFAULT_FIFO_DEPTH : defaults shared with the sonifier
//   DEFAULT_SAMPLE_W / DEFAULT_LEVEL_W  : widths derived from those defaults
//   sample_w() / level_w()              : same derivations for any parameter set
//   align_state_e                       : window-alignment FSM states
package logs_pkg;

  localparam int DEFAULT_WINDOW     = 256;
  localparam int DEFAULT_FIFO_DEPTH = 4;

  // A window of N clocks can hold 0..N high cycles, hence N+1 codes.
  function automatic int sample_w(input int window);
    return $clog2(window + 1);
  endfunction

  // The FIFO level spans 0..depth inclusive.
  function automatic int level_w(input int depth);
    return $clog2(depth + 1);
  endfunction

  localparam int DEFAULT_SAMPLE_W = sample_w(DEFAULT_WINDOW);
  localparam int DEFAULT_LEVEL_W  = level_w(DEFAULT_FIFO_DEPTH);

  typedef enum logic {
    ST_ALIGN = 1'b0,  // waiting for the first rising edge of the PWM bit
    ST_RUN   = 1'b1   // windows free-run from the captured edge
  } align_state_e;

endpackage

// File: rtl/logs_pwm_demod_if.sv
// logs_pwm_demod_if: sample stream plus FIFO status from the PWM demodulator.
//   sample_data  : high-cycle count of the oldest buffered window
//   sample_valid : sample_data holds a buffered sample
//   sample_ready : consumer accepts on sample_valid & sample_ready
//   overflow     : sticky, a window result was dropped
//   fifo_level   : number of buffered samples
// master = demodulator side, slave = consumer side.
interface logs_pwm_demod_if
  import logs_pkg::*;
#(
  parameter int SAMPLE_W = DEFAULT_SAMPLE_W,
  parameter int LEVEL_W  = DEFAULT_LEVEL_W
);

  logic [SAMPLE_W-1:0] sample_data;
  logic                sample_valid;
  logic                sample_ready;
  logic                overflow;
  logic [LEVEL_W-1:0]  fifo_level;

  modport master (
    output sample_data, sample_valid, overflow, fifo_level,
    input  sample_ready
  );

  modport slave (
    input  sample_data, sample_valid, overflow, fifo_level,
    output sample_ready
  );

endinterface

// File: rtl/logs_sample_fifo.sv
// logs_sample_fifo: show-ahead sample FIFO.
//   clk, reset : clock, asynchronous active-high reset
//   push/wdata : write request and data (ignored when full unless popping)
//   pop        : read request (ignored when empty)
//   rdata      : registered head entry; holds its last value when empty
//   empty/full/level : occupancy
// Push and pop on the same edge are both honoured, even when full.
module logs_sample_fifo #(
  parameter  int WIDTH   = 8,
  parameter  int DEPTH   = 4,
  localparam int LEVEL_W = $clog2(DEPTH + 1),
  localparam int PTR_W   = $clog2(DEPTH)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               push,
  input  logic [WIDTH-1:0]   wdata,
  input  logic               pop,
  output logic [WIDTH-1:0]   rdata,
  output logic               empty,
  output logic               full,
  output logic [LEVEL_W-1:0] level
);

  localparam logic [PTR_W-1:0]   PTR_ONE   = PTR_W'(1);
  localparam logic [LEVEL_W-1:0] LEVEL_ONE = LEVEL_W'(1);

  logic [WIDTH-1:0]   mem [DEPTH];
  logic [PTR_W-1:0]   wr_ptr, rd_ptr;
  logic [LEVEL_W-1:0] level_q;
  logic [WIDTH-1:0]   rdata_q;
  logic               do_push, do_pop;

  assign empty   = (level_q == '0);
  assign full    = (level_q == LEVEL_W'(DEPTH));
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign rdata   = rdata_q;
  assign level   = level_q;

  // NOTE: storage is not reset; only pointers and level need a known state,
  // and leaving the array reset-free lets it map onto plain RAM/flops.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      level_q <= '0;
      rdata_q <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
      if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;

      case ({do_push, do_pop})
        2'b10:   level_q <= level_q + LEVEL_ONE;
        2'b01:   level_q <= level_q - LEVEL_ONE;
        default: level_q <= level_q;
      endcase

      // Show-ahead head register: load whatever becomes the head this edge.
      // With a single entry being popped, the only candidate is the word
      // arriving on the same edge (if any).
      if (do_pop) begin
        if (level_q != LEVEL_ONE) rdata_q <= mem[rd_ptr + PTR_ONE];
        else if (do_push)         rdata_q <= wdata;
      end else if (do_push && empty) begin
        rdata_q <= wdata;
      end
    end
  end

endmodule

// File: rtl/logs_pwm_demod.sv
// logs_pwm_demod: recovers sample values from a 1-bit PWM audio stream by
// counting high cycles over windows of WINDOW clocks and queueing the counts.
//   clk, reset : clock, asynchronous active-high reset (clears all state)
//   pwm_in     : PWM audio bit, may be asynchronous to clk
//   smp        : sample stream + overflow/fifo_level status (master side)
// Optional build macro LOGS_DEMOD_EDGE_ALIGN_EN: hold the window counters
// idle after reset until the synchronized PWM bit first rises, so windows
// line up with PWM period starts.
module logs_pwm_demod
  import logs_pkg::*;
#(
  parameter int WINDOW     = DEFAULT_WINDOW,
  parameter int FIFO_DEPTH = DEFAULT_FIFO_DEPTH
) (
  input  logic clk,
  input  logic reset,
  input  logic pwm_in,
  logs_pwm_demod_if.master smp
);

  localparam int SAMPLE_W = sample_w(WINDOW);
  localparam int LEVEL_W  = level_w(FIFO_DEPTH);
  localparam int WIN_W    = $clog2(WINDOW);
  localparam logic [WIN_W-1:0] WIN_LAST = WIN_W'(WINDOW - 1);
  localparam logic [WIN_W-1:0] WIN_ONE  = WIN_W'(1);

  // Two-flop synchronizer; everything downstream uses s.
  logic sync1, s;

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values, which is what makes sync1 -> s a real 2-stage chain.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1 <= 1'b0;
      s     <= 1'b0;
    end else begin
      sync1 <= pwm_in;
      s     <= sync1;
    end
  end

  logic count_en;

`ifdef LOGS_DEMOD_EDGE_ALIGN_EN
  align_state_e state_q, state_d;
  logic         s_prev;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_ALIGN;
      s_prev  <= 1'b0;
    end else begin
      state_q <= state_d;
      s_prev  <= s;
    end
  end

  // The rising-edge cycle itself is window cycle 0, so counting is enabled
  // on that cycle as well as throughout ST_RUN.
  // NOTE: defaults first so every path assigns every output; no latches.
  always_comb begin
    state_d  = state_q;
    count_en = (state_q == ST_RUN);
    if (state_q == ST_ALIGN && s && !s_prev) begin
      state_d  = ST_RUN;
      count_en = 1'b1;
    end
  end
`else
  assign count_en = 1'b1;
`endif

  logic [WIN_W-1:0]    win_cnt;
  logic [SAMPLE_W-1:0] hi_cnt;
  logic [SAMPLE_W-1:0] result;
  logic                closing;

  // hi_cnt peaks at WINDOW-1 before the closing cycle, so the sum fits.
  assign result  = hi_cnt + SAMPLE_W'(s);
  assign closing = count_en && (win_cnt == WIN_LAST);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      win_cnt <= '0;
      hi_cnt  <= '0;
    end else if (count_en) begin
      win_cnt <= closing ? '0 : win_cnt + WIN_ONE;
      hi_cnt  <= closing ? '0 : result;
    end
  end

  logic fifo_empty, fifo_full;

  logs_sample_fifo #(
    .WIDTH (SAMPLE_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (closing),
    .wdata (result),
    .pop   (smp.sample_ready),
    .rdata (smp.sample_data),
    .empty (fifo_empty),
    .full  (fifo_full),
    .level (smp.fifo_level)
  );

  // A result is lost only when the FIFO is full and nothing leaves on the
  // same edge; full implies non-empty, so sample_ready alone means a pop.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                                       smp.overflow <= 1'b0;
    else if (closing && fifo_full && !smp.sample_ready) smp.overflow <= 1'b1;
  end

  assign smp.sample_valid = ~fifo_empty;

endmodule
